// File: rtl/vc_addr_encoder6_if.sv
// Bus between the VC request logic and the 6-way address encoder.
// VC_ADDR_PARITY_EN adds the addr_par line.
interface vc_addr_encoder6_if;
    logic [5:0] req;
    logic       ack;
    logic [2:0] addr;
    logic       addr_vld;
    logic [5:0] gnt;
    logic       timeout;
`ifdef VC_ADDR_PARITY_EN
    logic       addr_par;

    modport master (output req, ack, input addr, addr_vld, gnt, timeout, addr_par);
    modport slave  (input req, ack, output addr, addr_vld, gnt, timeout, addr_par);
`else
    modport master (output req, ack, input addr, addr_vld, gnt, timeout);
    modport slave  (input req, ack, output addr, addr_vld, gnt, timeout);
`endif
endinterface

// File: rtl/vc_addr_encoder6.sv
// Round-robin arbiter over six VC requests, emitting a held 3-bit address in the
// 6-way enable decoder's code. Optional even parity output via VC_ADDR_PARITY_EN.
module vc_addr_encoder6 #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    vc_addr_encoder6_if.slave  bus
);

    localparam bit         TO_EN   = (TO_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
    localparam logic [7:0] TO_SAT  = TO_EN ? 8'(TO_CYCLES) : 8'hFF;
    localparam logic [2:0] IDLE_CODE = 3'b111;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] gch;
    logic [7:0] cnt;
    logic [2:0] sel;
    logic       end_grant;
    logic       take_ptr;
    logic       fire_to;

    logic [2:0] addr_p1;
    logic       vld_p1;
    logic [5:0] gnt_p1;
    logic       to_p1;
`ifdef VC_ADDR_PARITY_EN
    logic       par_p1;
`endif

    // Gray-like decoder code: adjacent channels differ in one bit; 101 never used.
    function automatic logic [2:0] ch_code(input logic [2:0] ch);
        logic [2:0] c;
        case (ch)
            3'd0:    c = 3'b000;
            3'd1:    c = 3'b001;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b110;
            3'd5:    c = 3'b100;
            default: c = IDLE_CODE;
        endcase
        return c;
    endfunction

    // Lowest distance from ptr+1 wins; caller guarantees r != 0.
    function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] p);
        logic [2:0] s;
        int         idx;
        s = 3'd0;
        for (int k = 6; k >= 1; k--) begin
            idx = (int'(p) + k) % 6;
            if (r[idx]) s = 3'(idx);
        end
        return s;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= TO_SAT) ? c : c + 8'd1;
    endfunction

    function automatic logic even_par(input logic v, input logic [2:0] a);
        return ^{v, a};
    endfunction

    always_comb begin
        sel       = rr_pick(bus.req, ptr);
        end_grant = 1'b0;
        take_ptr  = 1'b0;
        fire_to   = 1'b0;
        if (state == GRANT) begin
            if (bus.ack) begin
                end_grant = 1'b1;
                take_ptr  = 1'b1;
            end else if ((gnt_p1 & bus.req) == 6'b0) begin
                end_grant = 1'b1;
            end else if (TO_EN && cnt == TO_LAST) begin
                end_grant = 1'b1;
                take_ptr  = 1'b1;
                fire_to   = 1'b1;
            end
        end
    end

    // p1: registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd5;
            gch     <= 3'd0;
            cnt     <= 8'd0;
            addr_p1 <= IDLE_CODE;
            vld_p1  <= 1'b0;
            gnt_p1  <= 6'b0;
            to_p1   <= 1'b0;
`ifdef VC_ADDR_PARITY_EN
            par_p1  <= even_par(1'b0, IDLE_CODE);
`endif
        end else begin
            to_p1 <= fire_to;
            case (state)
                IDLE: begin
                    if (bus.req != 6'b0) begin
                        state   <= GRANT;
                        gch     <= sel;
                        cnt     <= 8'd0;
                        addr_p1 <= ch_code(sel);
                        vld_p1  <= 1'b1;
                        gnt_p1  <= 6'b1 << sel;
`ifdef VC_ADDR_PARITY_EN
                        par_p1  <= even_par(1'b1, ch_code(sel));
`endif
                    end
                end
                GRANT: begin
                    if (end_grant) begin
                        state   <= IDLE;
                        addr_p1 <= IDLE_CODE;
                        vld_p1  <= 1'b0;
                        gnt_p1  <= 6'b0;
`ifdef VC_ADDR_PARITY_EN
                        par_p1  <= even_par(1'b0, IDLE_CODE);
`endif
                        if (take_ptr) ptr <= gch;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr     = addr_p1;
    assign bus.addr_vld = vld_p1;
    assign bus.gnt      = gnt_p1;
    assign bus.timeout  = to_p1;
`ifdef VC_ADDR_PARITY_EN
    assign bus.addr_par = par_p1;
`endif

endmodule

// File: tb/tb_vc_addr_encoder6.sv
// Directed bench for vc_addr_encoder6: reset, round-robin order, timeout,
// cancel vs ack, mid-grant reset and (with VC_ADDR_PARITY_EN) parity.
module tb_vc_addr_encoder6;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    vc_addr_encoder6_if bus ();

    vc_addr_encoder6 #(.TO_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] a,
                           input logic [5:0] g, input logic t);
        chk({tag, "_vld"}, 8'(bus.addr_vld), 8'(v));
        chk({tag, "_addr"}, 8'(bus.addr), 8'(a));
        chk({tag, "_gnt"}, 8'(bus.gnt), 8'(g));
        chk({tag, "_to"}, 8'(bus.timeout), 8'(t));
`ifdef VC_ADDR_PARITY_EN
        chk({tag, "_par"}, 8'(bus.addr_par), 8'(^{v, a}));
`endif
    endtask

    logic [2:0] exp_code [7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b000};
    logic [5:0] exp_gnt  [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};

    initial begin
        rst     = 1'b1;
        bus.req = 6'b0;
        bus.ack = 1'b0;

        // reset state
        tick();
        tick();
        chk_out("reset", 1'b0, 3'b111, 6'h00, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle_after_rst", 1'b0, 3'b111, 6'h00, 1'b0);

        // full round-robin sweep, one bubble between grants
        bus.req = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, exp_code[i], exp_gnt[i], 1'b0);
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            chk_out($sformatf("rr%0d_bubble", i), 1'b0, 3'b111, 6'h00, 1'b0);
        end
        bus.req = 6'b0;
        tick();
        chk_out("rr_done", 1'b0, 3'b111, 6'h00, 1'b0);

        // timeout on ch4 after 16 held cycles
        bus.req = 6'b001000;
        tick();
        for (int j = 0; j < 16; j++) begin
            chk_out($sformatf("to_hold%0d", j), 1'b1, 3'b010, 6'h08, 1'b0);
            tick();
        end
        chk_out("to_pulse", 1'b0, 3'b111, 6'h00, 1'b1);
        tick();
        chk_out("to_regrant", 1'b1, 3'b010, 6'h08, 1'b0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req = 6'b0;
        chk_out("to_acked", 1'b0, 3'b111, 6'h00, 1'b0);

        // set pointer to ch1
        bus.req = 6'b000001;
        tick();
        chk_out("c_ch1", 1'b1, 3'b000, 6'h01, 1'b0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req = 6'b000010;
        chk_out("c_idle0", 1'b0, 3'b111, 6'h00, 1'b0);
        tick();
        chk_out("c_ch2", 1'b1, 3'b001, 6'h02, 1'b0);
        // cancel: pointer stays at ch1
        bus.req = 6'b0;
        tick();
        chk_out("c_cancel", 1'b0, 3'b111, 6'h00, 1'b0);
        bus.req = 6'b000011;
        tick();
        chk_out("c_ch2_again", 1'b1, 3'b001, 6'h02, 1'b0);
        // drop together with ack: ack wins, pointer moves to ch2
        bus.req = 6'b000001;
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_out("c_ackdrop", 1'b0, 3'b111, 6'h00, 1'b0);
        bus.req = 6'b000011;
        tick();
        chk_out("c_ch1_next", 1'b1, 3'b000, 6'h01, 1'b0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req = 6'b0;
        chk_out("c_done", 1'b0, 3'b111, 6'h00, 1'b0);

        // reset mid-grant on ch5
        bus.req = 6'b010000;
        tick();
        chk_out("r_ch5", 1'b1, 3'b110, 6'h10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("r_dropped", 1'b0, 3'b111, 6'h00, 1'b0);
        bus.req = 6'b110000;
        tick();
        chk_out("r_ch5_first", 1'b1, 3'b110, 6'h10, 1'b0);
        // other request changes during a grant have no effect
        bus.req = 6'b010001;
        tick();
        chk_out("r_held", 1'b1, 3'b110, 6'h10, 1'b0);
        bus.ack = 1'b1;
        tick();
        bus.req = 6'b0;
        chk_out("r_acked", 1'b0, 3'b111, 6'h00, 1'b0);
        // ack with nothing valid is ignored
        tick();
        bus.ack = 1'b0;
        chk_out("ack_idle", 1'b0, 3'b111, 6'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
